// File: rtl/pc_fetch_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset/NOP constants, opcode values
// used by the control decoder, and small address helpers.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // JALR targets drop bit 0 of the computed sum.
    function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
        return addr & ~32'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_npc_gen.sv
// Next-PC generator: picks the redirect or sequential target for the issued
// instruction and flags targets that are not word aligned.
module npc_gen
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] data_rs1,
    input  logic        jmp_en,
    input  logic        jmpr_en,
    input  logic        jmpb_en,
    output logic [31:0] target,
    output logic        misaligned
);

    // JALR outranks JAL/branch; all sums wrap modulo 2^32.
    always_comb begin
        target = pc + 32'd4;
        if (jmpr_en) begin
            target = clear_lsb(data_rs1 + imm);
        end else if (jmp_en || jmpb_en) begin
            target = pc + imm;
        end
    end

    assign misaligned = target[1];

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: one request in flight, holds the fetched word for
// the execute stage and advances the PC when the instruction retires.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    input  logic        inst_ack,
    input  logic        jmp_en,
    input  logic        jmpr_en,
    input  logic        jmpb_en,
    input  logic [31:0] data_rs1,
    input  logic [31:0] imm,
    output logic        misalign_err
);

    fetch_state_t state;
    logic [31:0]  npc;
    logic         npc_misaligned;

    npc_gen u_npc_gen (
        .pc         (pc),
        .imm        (imm),
        .data_rs1   (data_rs1),
        .jmp_en     (jmp_en),
        .jmpr_en    (jmpr_en),
        .jmpb_en    (jmpb_en),
        .target     (npc),
        .misaligned (npc_misaligned)
    );

    // FETCH is entered either from reset (request not yet raised) or from an
    // acknowledged ISSUE (request already raised), so imem_req marks which.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            inst         <= NOP_INST;
            inst_valid   <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (inst_ack) begin
                        inst_valid <= 1'b0;
                        if (npc_misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= HALT;
                        end else begin
                            pc        <= npc;
                            imem_req  <= 1'b1;
                            imem_addr <= npc;
                            state     <= FETCH;
                        end
                    end
                end
                HALT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, redirects, wrap, stalls,
// reset during an outstanding request, and misaligned-target halt.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic        inst_ack;
    logic        jmp_en;
    logic        jmpr_en;
    logic        jmpb_en;
    logic [31:0] data_rs1;
    logic [31:0] imm;
    logic        misalign_err;

    int n_assert = 0;
    int n_fail   = 0;

    pc_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .inst_ack     (inst_ack),
        .jmp_en       (jmp_en),
        .jmpr_en      (jmpr_en),
        .jmpb_en      (jmpb_en),
        .data_rs1     (data_rs1),
        .imm          (imm),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in the request cycle; returns with the word presented in ISSUE.
    task automatic serve(input logic [31:0] data, input int delay);
        tick();
        chkb("wait_no_req", imem_req, 1'b0);
        for (int i = 0; i < delay; i++) begin
            tick();
            chkb("wait_idle_req", imem_req, 1'b0);
            chkb("wait_idle_valid", inst_valid, 1'b0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chkb("issue_valid", inst_valid, 1'b1);
        chk("issue_inst", inst, data);
    endtask

    task automatic ack(input logic j, input logic jr, input logic jb,
                       input logic [31:0] rs1, input logic [31:0] im);
        jmp_en   = j;
        jmpr_en  = jr;
        jmpb_en  = jb;
        data_rs1 = rs1;
        imm      = im;
        inst_ack = 1'b1;
        tick();
        inst_ack = 1'b0;
        jmp_en   = 1'b0;
        jmpr_en  = 1'b0;
        jmpb_en  = 1'b0;
        data_rs1 = 32'h0;
        imm      = 32'h0;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ack    = 1'b0;
        jmp_en      = 1'b0;
        jmpr_en     = 1'b0;
        jmpb_en     = 1'b0;
        data_rs1    = 32'h0;
        imm         = 32'h0;

        // Reset values
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chkb("rst_inst_valid", inst_valid, 1'b0);
        chkb("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chkb("rst_misalign", misalign_err, 1'b0);

        // First request on the first edge after release
        rst_n = 1'b1;
        tick();
        chkb("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential fetch 0x0, 0x4, 0x8 with immediate ack
        serve(32'h0010_0093, 0);
        chk("seq0_pc", pc, 32'h0);
        ack(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chkb("seq0_valid_drop", inst_valid, 1'b0);
        chkb("seq1_req", imem_req, 1'b1);
        chk("seq1_addr", imem_addr, 32'h4);
        serve(32'h0020_0113, 0);
        chk("seq1_pc", pc, 32'h4);
        ack(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chkb("seq2_req", imem_req, 1'b1);
        chk("seq2_addr", imem_addr, 32'h8);

        // JAL forward to 0x100, then backward by 16 to 0xF0
        serve(32'h0F80_006F, 0);
        ack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_00F8);
        chk("jal_fwd_addr", imem_addr, 32'h100);
        serve(32'hFF1F_F06F, 0);
        chk("jal_fwd_pc", pc, 32'h100);
        ack(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF0);
        chkb("jal_back_req", imem_req, 1'b1);
        chk("jal_back_addr", imem_addr, 32'hF0);

        // JALR and JAL together: JALR wins, bit 0 cleared
        serve(32'h0010_8067, 0);
        chk("jalr_pc_before", pc, 32'hF0);
        ack(1'b1, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_0001);
        chk("jalr_addr", imem_addr, 32'h204);
        chk("jalr_pc", pc, 32'h204);

        // Slow memory, stalled ack, stray rvalid in ISSUE
        serve(32'h1234_5678, 5);
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_0000 + 32'(i);
            tick();
            chk("stall_inst", inst, 32'h1234_5678);
            chk("stall_pc", pc, 32'h204);
            chkb("stall_valid", inst_valid, 1'b1);
            chkb("stall_no_req", imem_req, 1'b0);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        ack(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("stall_next_addr", imem_addr, 32'h208);

        // ack/jump outside ISSUE ignored, then reset during WAIT
        tick();
        inst_ack = 1'b1;
        jmp_en   = 1'b1;
        imm      = 32'h40;
        tick();
        chk("ign_ack_pc", pc, 32'h208);
        chkb("ign_ack_req", imem_req, 1'b0);
        chkb("ign_ack_valid", inst_valid, 1'b0);
        inst_ack = 1'b0;
        jmp_en   = 1'b0;
        imm      = 32'h0;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_inst", inst, 32'h0000_0013);
        chkb("midrst_req", imem_req, 1'b0);
        chkb("midrst_valid", inst_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBBBB_BBBB;
        tick();
        rst_n = 1'b1;
        tick();
        chkb("postrst_req", imem_req, 1'b1);
        chk("postrst_addr", imem_addr, 32'h0);
        chk("postrst_inst", inst, 32'h0000_0013);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // Wrap from 0xFFFF_FFFC to 0 without error
        serve(32'h0040_0067, 0);
        ack(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0004);
        chk("wrap_hi_addr", imem_addr, 32'hFFFF_FFFC);
        serve(32'h0000_0013, 0);
        chk("wrap_hi_pc", pc, 32'hFFFF_FFFC);
        ack(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chkb("wrap_no_err", misalign_err, 1'b0);

        // Branch to misaligned target halts the fetch unit
        serve(32'h0100_006F, 0);
        ack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0010);
        chk("br_setup_addr", imem_addr, 32'h10);
        serve(32'h0000_0363, 0);
        ack(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0006);
        chkb("mis_err", misalign_err, 1'b1);
        chkb("mis_req", imem_req, 1'b0);
        chkb("mis_valid", inst_valid, 1'b0);
        chk("mis_pc", pc, 32'h10);
        for (int i = 0; i < 6; i++) begin
            imem_rvalid = 1'b1;
            inst_ack    = 1'b1;
            tick();
            chkb("halt_req", imem_req, 1'b0);
            chkb("halt_valid", inst_valid, 1'b0);
            chkb("halt_err", misalign_err, 1'b1);
        end
        imem_rvalid = 1'b0;
        inst_ack    = 1'b0;

        // Only reset leaves HALT
        rst_n = 1'b0;
        #1;
        chkb("halt_rst_err", misalign_err, 1'b0);
        chk("halt_rst_pc", pc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chkb("halt_rst_req", imem_req, 1'b1);
        chk("halt_rst_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
